// File: rtl/ps2_pkg.sv
// Shared constants and state encodings for the PS/2 receive path.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam int         PS2_FRAME_BITS = 11;

  typedef enum logic {
    RX_IDLE,
    RX_SHIFT
  } rx_state_t;

  // F_EXT / F_EXT_BREAK are only entered when extended-code handling is built in.
  typedef enum logic [1:0] {
    F_IDLE,
    F_BREAK,
    F_EXT,
    F_EXT_BREAK
  } fr_state_t;

  // Odd parity over data+parity: an even count of ones is an error.
  function automatic logic odd_par_err(input logic [8:0] data_par);
    return ~^data_par;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Pin synchroniser (reset to idle-high) with falling-edge detector.
module ps2_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic level,
  output logic fall
);

  // sync_q[STAGES-1] is the synchronised level, sync_q[STAGES] its previous value.
  logic [STAGES:0] sync_q;

  // Shift the raw pin through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (!reset_n) sync_q <= '1;
    else          sync_q <= {sync_q[STAGES-1:0], pin};
  end

  assign level = sync_q[STAGES-1];
  assign fall  = sync_q[STAGES] & ~sync_q[STAGES-1];

endmodule

// File: rtl/ps2_rx_framer.sv
// PS/2 device-to-host receiver and scan-code framer.
// Build option: define PS2_EXT_EN to absorb E0 prefixes (E0 xx -> make xx,
// E0 F0 xx -> break F0/xx). Without it E0 is framed as an ordinary make byte.
module ps2_rx_framer
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code1,
  output logic [7:0] code2,
  output logic       par_err1,
  output logic       par_err2,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int         TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] BIT_LAST = 4'(PS2_FRAME_BITS - 1);

  logic clk_lvl, clk_fall, data_lvl;

  ps2_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .reset_n(reset_n), .pin(ps2_clk), .level(clk_lvl), .fall(clk_fall)
  );

  ps2_sync #(.STAGES(SYNC_STAGES)) u_sync_data (
    .clk(clk), .reset_n(reset_n), .pin(ps2_data), .level(data_lvl), .fall()
  );

  rx_state_t      rx_state;
  fr_state_t      fr_state;
  logic [3:0]     bit_cnt;
  logic [8:0]     shreg;      // {parity, data[7:0]} once bits 1..9 are in
  logic [TW-1:0]  tmo;

  logic       tmo_hit, at_stop, byte_done, rx_fail;
  logic [7:0] rx_byte;
  logic       rx_perr;

  // Timeout wins over a coincident edge; a completed byte needs a good stop bit.
  assign tmo_hit   = (rx_state == RX_SHIFT) && (tmo == TMO_LAST);
  assign at_stop   = (rx_state == RX_SHIFT) && (bit_cnt == BIT_LAST);
  assign byte_done = !tmo_hit && clk_fall && at_stop && data_lvl;
  assign rx_fail   = tmo_hit ||
                     (clk_fall && (((rx_state == RX_IDLE) && data_lvl) ||
                                   (at_stop && !data_lvl)));
  assign rx_byte   = shreg[7:0];
  assign rx_perr   = odd_par_err(shreg);

  // Receiver FSM: start/data/parity/stop sampling on synchronised falling edges.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_state  <= RX_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      tmo       <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= rx_fail;
      if (tmo_hit) begin
        rx_state <= RX_IDLE;
        bit_cnt  <= '0;
        tmo      <= '0;
      end else if (clk_fall) begin
        tmo <= '0;
        case (rx_state)
          RX_IDLE: begin
            if (!data_lvl) begin
              rx_state <= RX_SHIFT;
              bit_cnt  <= 4'd1;
            end
          end
          RX_SHIFT: begin
            if (bit_cnt == BIT_LAST) begin
              rx_state <= RX_IDLE;
              bit_cnt  <= '0;
            end else begin
              shreg   <= {data_lvl, shreg[8:1]};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          default: rx_state <= RX_IDLE;
        endcase
      end else if (rx_state == RX_SHIFT) begin
        tmo <= tmo + 1'b1;
      end
    end
  end

  // Framer FSM: groups good bytes into make / break codes, held as levels.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fr_state   <= F_IDLE;
      code1      <= '0;
      code2      <= '0;
      par_err1   <= 1'b0;
      par_err2   <= 1'b0;
      code_valid <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      if (rx_fail) begin
        fr_state <= F_IDLE;
      end else if (byte_done) begin
        case (fr_state)
          F_IDLE: begin
            code1    <= rx_byte;
            code2    <= '0;
            par_err1 <= rx_perr;
            par_err2 <= 1'b0;
            if (rx_byte == PS2_BREAK) begin
              fr_state <= F_BREAK;
            end
`ifdef PS2_EXT_EN
            else if (rx_byte == PS2_EXT) begin
              // Prefix is absorbed: restore nothing visible, just remember it.
              code1    <= code1;
              code2    <= code2;
              par_err1 <= par_err1;
              par_err2 <= par_err2;
              fr_state <= F_EXT;
            end
`endif
            else begin
              code_valid <= 1'b1;
            end
          end
`ifdef PS2_EXT_EN
          F_EXT: begin
            code1    <= rx_byte;
            code2    <= '0;
            par_err1 <= rx_perr;
            par_err2 <= 1'b0;
            if (rx_byte == PS2_BREAK) begin
              fr_state <= F_EXT_BREAK;
            end else begin
              code_valid <= 1'b1;
              fr_state   <= F_IDLE;
            end
          end
          F_EXT_BREAK: begin
            code2      <= rx_byte;
            par_err2   <= rx_perr;
            code_valid <= 1'b1;
            fr_state   <= F_IDLE;
          end
`endif
          F_BREAK: begin
            code2      <= rx_byte;
            par_err2   <= rx_perr;
            code_valid <= 1'b1;
            fr_state   <= F_IDLE;
          end
          default: fr_state <= F_IDLE;
        endcase
      end
    end
  end

  // Synchronised clock level is only needed for edge detection.
  logic unused_ok;
  assign unused_ok = clk_lvl;

endmodule

// File: tb/tb_ps2_rx_framer.sv
// Directed bench for ps2_rx_framer with a scoreboard of expected codes.
module tb_ps2_rx_framer;

  localparam int TMO = 200;
  localparam int H   = 20;   // half PS/2 bit period in clk cycles

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] code1, code2;
  logic       par_err1, par_err2, code_valid, frame_err;

  ps2_rx_framer #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code1(code1), .code2(code2), .par_err1(par_err1), .par_err2(par_err2),
    .code_valid(code_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] c1;
    logic [7:0] c2;
    logic       p1;
    logic       p2;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_fe  = 0;
  int   exp_fe = 0;

  // Scoreboard monitor: every code_valid pulse pops one expected code.
  always @(negedge clk) begin
    if (reset_n && (code_valid || frame_err)) begin
      n_cmp++;
      assert (!(code_valid && frame_err)) else begin
        n_bad++; $error("FAIL excl: code_valid=%0b frame_err=%0b, need not both", code_valid, frame_err);
      end
    end
    if (reset_n && frame_err) n_fe++;
    if (reset_n && code_valid) begin
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_bad++; $error("FAIL sb_empty: got code %h/%h, none expected", code1, code2);
      end
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n_cmp++;
        assert ({code1, code2, par_err1, par_err2} === e) else begin
          n_bad++; $error("FAIL sb_code: got %h/%h pe %b%b, need %h/%h pe %b%b",
                          code1, code2, par_err1, par_err2, e.c1, e.c2, e.p1, e.p2);
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] c1, input logic [7:0] c2, input logic p1, input logic p2);
    exp_q.push_back('{c1: c1, c2: c2, p1: p1, p2: p2});
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = (~^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      wait_clk(H);
      ps2_clk = 1'b0;
      wait_clk(H);
      ps2_clk = 1'b1;
    end
    wait_clk(H);
    ps2_data = 1'b1;
  endtask

  task automatic frame(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0);
    send_bits(mk_frame(b, bad_par, bad_stop), 11);
    wait_clk(10);
  endtask

  task automatic chk_lvl(input string tag, input logic [7:0] c1, input logic [7:0] c2,
                         input logic p1, input logic p2);
    n_cmp++;
    assert ({code1, code2, par_err1, par_err2} === {c1, c2, p1, p2}) else begin
      n_bad++; $error("FAIL %s: got %h/%h pe %b%b, need %h/%h pe %b%b",
                      tag, code1, code2, par_err1, par_err2, c1, c2, p1, p2);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++; $error("FAIL %s: got %0d, need %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    wait_clk(4);
    chk_lvl("reset", 8'h00, 8'h00, 1'b0, 1'b0);
    chk_int("reset_pulses", {30'd0, code_valid, frame_err}, 0);
    reset_n = 1'b1;
    wait_clk(10);

    // 1: make 1C
    push(8'h1C, 8'h00, 1'b0, 1'b0);
    frame(8'h1C);
    chk_lvl("make_1c", 8'h1C, 8'h00, 1'b0, 1'b0);
    chk_int("make_1c_drain", exp_q.size(), 0);

    // 2: break F0 1C
    frame(8'hF0);
    chk_lvl("break_f0_hold", 8'hF0, 8'h00, 1'b0, 1'b0);
    push(8'hF0, 8'h1C, 1'b0, 1'b0);
    frame(8'h1C);
    chk_lvl("break_1c", 8'hF0, 8'h1C, 1'b0, 1'b0);
    chk_int("break_drain", exp_q.size(), 0);

    // 3: parity errors
    push(8'h23, 8'h00, 1'b1, 1'b0);
    frame(8'h23, 1);
    chk_lvl("perr_make", 8'h23, 8'h00, 1'b1, 1'b0);
    frame(8'hF0);
    push(8'hF0, 8'h23, 1'b0, 1'b1);
    frame(8'h23, 1);
    chk_lvl("perr_break", 8'hF0, 8'h23, 1'b0, 1'b1);

    // 4: bad stop bit
    exp_fe++;
    frame(8'h24, 0, 1);
    chk_lvl("stop_hold", 8'hF0, 8'h23, 1'b0, 1'b1);
    chk_int("stop_fe", n_fe, exp_fe);

    // 5: timeout mid-frame, then a clean frame
    send_bits(mk_frame(8'h55, 0, 0), 6);
    exp_fe++;
    wait_clk(TMO + 40);
    chk_int("tmo_fe", n_fe, exp_fe);
    chk_lvl("tmo_hold", 8'hF0, 8'h23, 1'b0, 1'b1);
    push(8'h2B, 8'h00, 1'b0, 1'b0);
    frame(8'h2B);
    chk_lvl("after_tmo", 8'h2B, 8'h00, 1'b0, 1'b0);

    // 6: extended codes
`ifdef PS2_EXT_EN
    push(8'h75, 8'h00, 1'b0, 1'b0);
    frame(8'hE0);
    chk_lvl("ext_absorb", 8'h2B, 8'h00, 1'b0, 1'b0);
    frame(8'h75);
    chk_lvl("ext_make", 8'h75, 8'h00, 1'b0, 1'b0);
    push(8'hF0, 8'h75, 1'b0, 1'b0);
    frame(8'hE0);
    frame(8'hF0);
    frame(8'h75);
`else
    push(8'hE0, 8'h00, 1'b0, 1'b0);
    frame(8'hE0);
    chk_lvl("e0_make", 8'hE0, 8'h00, 1'b0, 1'b0);
    push(8'h75, 8'h00, 1'b0, 1'b0);
    frame(8'h75);
    chk_lvl("e0_next", 8'h75, 8'h00, 1'b0, 1'b0);
    push(8'hE0, 8'h00, 1'b0, 1'b0);
    frame(8'hE0);
    frame(8'hF0);
    push(8'hF0, 8'h75, 1'b0, 1'b0);
    frame(8'h75);
`endif
    chk_lvl("ext_break", 8'hF0, 8'h75, 1'b0, 1'b0);
    chk_int("ext_drain", exp_q.size(), 0);

    // Reset mid-frame, then recovery
    send_bits(mk_frame(8'h3A, 0, 0), 5);
    reset_n = 1'b0;
    wait_clk(3);
    chk_lvl("mid_reset", 8'h00, 8'h00, 1'b0, 1'b0);
    chk_int("mid_reset_pulses", {30'd0, code_valid, frame_err}, 0);
    reset_n = 1'b1;
    wait_clk(10);
    push(8'h1C, 8'h00, 1'b0, 1'b0);
    frame(8'h1C);
    chk_lvl("post_reset", 8'h1C, 8'h00, 1'b0, 1'b0);

    wait_clk(20);
    chk_int("final_drain", exp_q.size(), 0);
    chk_int("final_fe", n_fe, exp_fe);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_rx_framer.md
# ps2_rx_framer

Front end of the keyboard path. It synchronises the raw PS/2 clock and data pins, deserialises 11-bit device-to-host frames and checks their parity. It then groups bytes into complete scan codes and presents them as the `code1`/`code2`/`par_err1`/`par_err2` bundle consumed directly by the downstream key decoder. A make code appears in `code1`. A break appears as `code1 = 8'hF0` with `code2` holding the key byte.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop depth of the pin synchronisers (minimum 2).
- `TIMEOUT_CYCLES`, default 5000: number of `clk` cycles with no falling `ps2_clk` edge after which a partial frame is aborted.

Ports:
- `clk` in 1: system clock; the only clock in the block.
- `reset_n` in 1: reset, synchronous, active-low.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous to `clk`.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous to `clk`.
- `code1` out 8: first byte of the current scan code (key byte, or `F0` for a break).
- `code2` out 8: second byte of a break code; `00` for a make.
- `par_err1` out 1: parity error on the byte in `code1`.
- `par_err2` out 1: parity error on the byte in `code2`.
- `code_valid` out 1: one-cycle pulse when `code1`/`code2` take a new complete code.
- `frame_err` out 1: one-cycle pulse on a bad start/stop bit or a timeout abort.

## Operation
- **Synchronisers**: `ps2_clk` and `ps2_data` each pass through `SYNC_STAGES` flops, reset to 1 (idle bus). A falling edge is synchronised-clock previous = 1 and current = 0.
- **Receiver FSM**: states `RX_IDLE` and `RX_SHIFT`, with a 4-bit bit counter.
  - On each detected falling edge, sample the synchronised data.
  - Bit 0 is the start bit and must be 0. A start bit of 1 gives `frame_err` and a return to `RX_IDLE`.
  - Bits 1–8 are data, LSB first. Bit 9 is odd parity. Bit 10 is the stop bit and must be 1.
  - Bad stop bit: `frame_err` pulse, byte discarded.
  - Parity error: `par_err = ~^{data, parity}`. A byte with a parity error is still delivered, flagged.
- **Timeout**: the counter clears on every falling edge and counts while in `RX_SHIFT`. On reaching `TIMEOUT_CYCLES-1`: abort to `RX_IDLE`, pulse `frame_err`, and return the framer to `F_IDLE`.
- **Framer FSM**: states `F_IDLE` and `F_BREAK`; it runs once per good byte.
  - `F_IDLE`, byte ≠ `F0`: `code1` ← byte, `code2` ← `00`, `par_err1` ← its flag, `par_err2` ← 0, pulse `code_valid`.
  - `F_IDLE`, byte = `F0`: `code1` ← `F0`, `code2` ← `00`, `par_err1` ← its flag, `par_err2` ← 0, go to `F_BREAK`, no `code_valid`.
  - `F_BREAK`: `code2` ← byte, `par_err2` ← its flag, pulse `code_valid`, go to `F_IDLE`.
- Outputs are held as levels until the next byte is framed.
- Idle between codes: the decoder sees the last code steadily. In `F_BREAK`, `code2 = 00` matches no key, so no false break is decoded.
- A frame error discards the byte, leaves `code1`/`code2`/`par_err*` unchanged and returns the framer to `F_IDLE`.
- **Reset** (`reset_n = 0` at a `clk` edge, including mid-frame):
  - `code1 = 00`, `code2 = 00`, `par_err1 = 0`, `par_err2 = 0`, `code_valid = 0`, `frame_err = 0`.
  - Both FSMs idle, counters 0, any partial frame dropped.

## Timing
- Edge detection occurs `SYNC_STAGES+1` `clk` cycles after a pin transition.
- Outputs and the `code_valid` pulse update on the `clk` edge after the 11th falling edge is detected.
- `frame_err` asserts on the `clk` edge after the failing bit's edge is detected, or after the timeout count expires.
- `code_valid` and `frame_err` are never asserted in the same cycle.
- There is no back-pressure: the consumer must sample within the `code_valid` cycle, or treat the outputs as levels.
- A falling edge coinciding with timeout expiry: the timeout takes precedence and the edge is ignored.

## Configuration
- `PS2_EXT_EN` defined:
  - Framer adds states `F_EXT` and `F_EXT_BREAK`.
  - An `E0` byte is absorbed without output. `E0 xx` presents as make `xx`; `E0 F0 xx` presents as break `F0`/`xx`.
  - `E1` is not special.
- `PS2_EXT_EN` undefined: `E0` is framed as an ordinary make byte (`code1 = E0`, `code_valid` pulse).

## Structure
- Package `ps2_pkg`:
  - Constants `PS2_BREAK = 8'hF0`, `PS2_EXT = 8'hE0`, `PS2_FRAME_BITS = 11`.
  - Enum typedefs `rx_state_t` and `fr_state_t`.
- Sub-module `ps2_sync`: the parameterised synchroniser plus falling-edge detector, instantiated once for `ps2_clk` and once for `ps2_data`. The data instance uses only the synchronised level.

## Test plan
1. Frame `1C` with correct parity → `code1 = 1C`, `code2 = 00`, `par_err1 = 0`, one `code_valid` pulse.
2. Frames `F0` then `1C` → after `F0`: `code1 = F0`, `code2 = 00`, no pulse. After `1C`: `code2 = 1C`, one pulse.
3. Frame `23` with an inverted parity bit → `code1 = 23`, `par_err1 = 1`, `code_valid` pulse. Then `F0` with good parity and `23` with bad parity → `par_err1 = 0`, `par_err2 = 1`.
4. Frame `24` with stop bit 0 → `frame_err` pulse, outputs keep their previous values, no `code_valid`.
5. Six bits, then `ps2_clk` held high for `TIMEOUT_CYCLES` → `frame_err` pulse. A following full `2B` frame yields `code1 = 2B`.
6. `E0 75`, then `E0 F0 75` → with `PS2_EXT_EN`: `code1 = 75`, then `F0`/`75`. Without it: `code1 = E0` pulse, then `code1 = 75`. Additionally, `reset_n` low mid-frame → all outputs 0, and the next frame decodes correctly.
